// File: rtl/io_port_responder.sv
// ============================================================================
// Module      : io_port_responder
// Description : Peripheral responder for CPU IN/OUT cycles. Decodes a data
//               port at BASE_ADDR and a status port at BASE_ADDR+1, with a
//               TX FIFO toward a sink and an RX holding register from a source.
//               Optional macro IO_LOOPBACK_EN adds an internal TX->RX loopback
//               mode controlled by status bit 7.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_port_responder #(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter int          TX_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       io_addr_load,
    input  logic       io_write,
    input  logic       io_read,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       overflow
);

    localparam int               PTR_W     = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL    = CNT_W'(TX_DEPTH);
    localparam logic [7:0]       STAT_ADDR = BASE_ADDR + 8'd1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEL_DATA = 2'd1,
        SEL_STAT = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [7:0]       addr_q,     addr_d;
    logic [7:0]       bus_out_q,  bus_out_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [7:0]       rx_q,       rx_d;
    logic             rx_full_q,  rx_full_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       fifo_q [TX_DEPTH];

    logic       w_wr_stb, w_rd_stb;
    logic       w_tx_empty, w_tx_full;
    logic       w_loop, w_lb_pop, w_pop, w_push, w_full_eff;
    logic       w_drop, w_stat_wr, w_rx_clr, w_ext_cap;
    logic [7:0] w_head, w_status;

`ifdef IO_LOOPBACK_EN
    logic loop_q, loop_d;
    assign w_loop = loop_q;
`else
    assign w_loop = 1'b0;
`endif

    // Address load outranks write, which outranks read.
    assign w_wr_stb   = io_write && !io_addr_load;
    assign w_rd_stb   = io_read && !io_addr_load && !io_write;

    assign w_tx_empty = (cnt_q == '0);
    assign w_tx_full  = (cnt_q == C_FULL);
    assign w_head     = fifo_q[rd_ptr_q];

    assign tx_valid   = !w_tx_empty && !w_loop;
    assign tx_data    = w_tx_empty ? 8'h00 : w_head;
    assign rx_ready   = !rx_full_q && !w_loop;
    assign overflow   = overflow_q;
    assign bus_out    = bus_out_q;
    assign bus_oe     = io_read && (state_q != IDLE);

    assign w_lb_pop   = w_loop && !w_tx_empty && !rx_full_q;
    assign w_pop      = (tx_valid && tx_ready) || w_lb_pop;
    // A same-cycle pop frees a slot, so push at full is still accepted.
    assign w_full_eff = w_tx_full && !w_pop;
    assign w_push     = w_wr_stb && (state_q == SEL_DATA) && !w_full_eff;
    assign w_drop     = w_wr_stb && (state_q == SEL_DATA) && w_full_eff;
    assign w_stat_wr  = w_wr_stb && (state_q == SEL_STAT);
    assign w_rx_clr   = w_rd_stb && (state_q == SEL_DATA);
    assign w_ext_cap  = rx_valid && rx_ready;

    assign w_status   = {w_loop, 3'b000, overflow_q, rx_full_q, w_tx_full, w_tx_empty};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        bus_out_d  = bus_out_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        rx_d       = rx_q;
        rx_full_d  = rx_full_q;
        overflow_d = overflow_q;
`ifdef IO_LOOPBACK_EN
        loop_d     = loop_q;
`endif

        if (io_addr_load) begin
            addr_d = bus_in;
            if (bus_in == BASE_ADDR) begin
                state_d   = SEL_DATA;
                bus_out_d = rx_full_q ? rx_q : 8'h00;
            end else if (bus_in == STAT_ADDR) begin
                state_d   = SEL_STAT;
                bus_out_d = w_status;
            end else begin
                state_d   = IDLE;
                bus_out_d = 8'h00;
            end
        end else if ((w_wr_stb || w_rd_stb) && (state_q != IDLE)) begin
            state_d = IDLE;
        end

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        if (w_stat_wr) begin
            overflow_d = 1'b0;
`ifdef IO_LOOPBACK_EN
            loop_d     = bus_in[7];
`endif
        end
        if (w_drop) begin
            overflow_d = 1'b1;
        end

        // Capture is ordered last; it can only fire while the register is empty.
        if (w_rx_clr) begin
            rx_full_d = 1'b0;
        end
        if (w_lb_pop) begin
            rx_d      = w_head;
            rx_full_d = 1'b1;
        end else if (w_ext_cap) begin
            rx_d      = rx_data;
            rx_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= 8'h00;
            bus_out_q  <= 8'h00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            rx_q       <= 8'h00;
            rx_full_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            bus_out_q  <= bus_out_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            rx_q       <= rx_d;
            rx_full_q  <= rx_full_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef IO_LOOPBACK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loop_q <= 1'b0;
        end else begin
            loop_q <= loop_d;
        end
    end
`endif

    // Storage needs no reset: tx_data is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_q[wr_ptr_q] <= bus_in;
        end
    end

    logic w_unused;
    assign w_unused = ^addr_q;

endmodule

`default_nettype wire

// File: tb/tb_io_port_responder.sv
// ============================================================================
// Module      : tb_io_port_responder
// Description : Scoreboard bench for io_port_responder: expected bus reads and
//               sink deliveries are queued by the stimulus, a monitor pops them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_port_responder;

    logic       clk;
    logic       reset_n;
    logic       io_addr_load;
    logic       io_write;
    logic       io_read;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       overflow;

    int total;
    int bad;

    logic [7:0] rd_q [$];
    logic [7:0] tx_q [$];

    io_port_responder #(
        .BASE_ADDR (8'h00),
        .TX_DEPTH  (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .io_addr_load (io_addr_load),
        .io_write     (io_write),
        .io_read      (io_read),
        .bus_in       (bus_in),
        .bus_out      (bus_out),
        .bus_oe       (bus_oe),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [7:0] a);
        io_addr_load = 1'b1;
        bus_in       = a;
        tick();
        io_addr_load = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] exp);
        rd_q.push_back(exp);
        io_read = 1'b1;
        tick();
        io_read = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] d);
        io_write = 1'b1;
        bus_in   = d;
        tick();
        io_write = 1'b0;
    endtask

    // Monitor: compares bus reads and sink deliveries against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (bus_oe) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_bus_read", bus_out, 8'hxx);
                end else begin
                    check("bus_read", bus_out, rd_q.pop_front());
                end
            end
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    check("unexpected_tx", tx_data, 8'hxx);
                end else begin
                    check("tx_deliver", tx_data, tx_q.pop_front());
                end
            end
        end
    end

    initial begin
        total        = 0;
        bad          = 0;
        reset_n      = 1'b0;
        io_addr_load = 1'b0;
        io_write     = 1'b0;
        io_read      = 1'b0;
        bus_in       = 8'h00;
        tx_ready     = 1'b0;
        rx_data      = 8'h00;
        rx_valid     = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        check("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
        check("rst_tx_data",  tx_data, 8'h00);
        check("rst_rx_ready", {7'd0, rx_ready}, 8'h01);
        check("rst_overflow", {7'd0, overflow}, 8'h00);
        check("rst_bus_oe",   {7'd0, bus_oe}, 8'h00);
        check("rst_bus_out",  bus_out, 8'h00);

        // Status after reset: tx_empty only
        set_addr(8'h01);
        do_read(8'h01);

        // Single OUT then one-cycle drain
        set_addr(8'h00);
        do_write(8'hA5);
        check("out_tx_valid", {7'd0, tx_valid}, 8'h01);
        check("out_tx_data",  tx_data, 8'hA5);
        tx_q.push_back(8'hA5);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("drain_tx_valid", {7'd0, tx_valid}, 8'h00);

        // Overflow: five OUTs into a four-deep FIFO
        for (int b = 1; b <= 5; b++) begin
            set_addr(8'h00);
            do_write(8'(b));
        end
        check("ovf_set", {7'd0, overflow}, 8'h01);
        set_addr(8'h01);
        do_read(8'h0A);
        set_addr(8'h01);
        do_write(8'hFF);
        check("ovf_clear", {7'd0, overflow}, 8'h00);
        for (int b = 1; b <= 4; b++) tx_q.push_back(8'(b));
        tx_ready = 1'b1;
        repeat (4) tick();
        tx_ready = 1'b0;
        check("ovf_drained", {7'd0, tx_valid}, 8'h00);

        // RX capture and IN from the data port
        rx_valid = 1'b1;
        rx_data  = 8'h3C;
        tick();
        rx_valid = 1'b0;
        check("rx_ready_low", {7'd0, rx_ready}, 8'h00);
        set_addr(8'h01);
        do_read(8'h05);
        set_addr(8'h00);
        do_read(8'h3C);
        check("rx_ready_back", {7'd0, rx_ready}, 8'h01);
        set_addr(8'h00);
        do_read(8'h00);

        // Unmapped address keeps the bus released; reselection wins
        set_addr(8'h07);
        io_read = 1'b1;
        #1;
        check("unmapped_oe", {7'd0, bus_oe}, 8'h00);
        tick();
        io_read = 1'b0;
        set_addr(8'h00);
        set_addr(8'h01);
        do_read(8'h01);

        // Push and pop at full in the same cycle
        for (int b = 1; b <= 4; b++) begin
            set_addr(8'h00);
            do_write(8'(b * 8'h11));
        end
        set_addr(8'h00);
        tx_q.push_back(8'h11);
        tx_q.push_back(8'h22);
        tx_q.push_back(8'h33);
        tx_q.push_back(8'h44);
        tx_q.push_back(8'h77);
        tx_ready = 1'b1;
        do_write(8'h77);
        check("full_pushpop_ovf", {7'd0, overflow}, 8'h00);
        check("full_pushpop_head", tx_data, 8'h22);
        repeat (4) tick();
        tx_ready = 1'b0;
        check("full_pushpop_empty", {7'd0, tx_valid}, 8'h00);

        // Reset between SET_ADDR and IN aborts the access
        set_addr(8'h00);
        do_write(8'h99);
        set_addr(8'h00);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        io_read = 1'b1;
        #1;
        check("abort_oe", {7'd0, bus_oe}, 8'h00);
        check("abort_tx_valid", {7'd0, tx_valid}, 8'h00);
        check("abort_bus_out", bus_out, 8'h00);
        tick();
        io_read = 1'b0;
        tick();

        check("rd_queue_empty", 8'(rd_q.size()), 8'h00);
        check("tx_queue_empty", 8'(tx_q.size()), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
